// File: rtl/reg_file_64.sv
// reg_file_64: 2R/1W register file, combinational reads, top index is XZR.
// Define REGFILE_BYPASS_EN for same-cycle write-through to the read ports.
module reg_file_64 #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RW,
  input  logic [DATA_W-1:0] BusW,
  input  logic              RegWr,
  output logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] BusB
);

  localparam int NSTORE = NUM_REGS - 1;
  localparam logic [ADDR_W-1:0] XZR =
    ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] r_regs [NSTORE];

  logic              w_wr_ok;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  // XZR and anything above it are not writable
  assign w_wr_ok = (RW < XZR);
  assign w_wr_en = RegWr & w_wr_ok;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NSTORE; i++)
        r_regs[i] <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < NSTORE; i++)
        if (RW == ADDR_W'(i))
          r_regs[i] <= BusW;
    end
  end

  // unmatched addresses (XZR, out of range) fall to 0
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int i = 0; i < NSTORE; i++) begin
      if (RA == ADDR_W'(i))
        w_rd_a = r_regs[i];
      if (RB == ADDR_W'(i))
        w_rd_b = r_regs[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_byp_a;
  logic w_byp_b;

  assign w_byp_a = Reset_n & w_wr_en & (RA == RW);
  assign w_byp_b = Reset_n & w_wr_en & (RB == RW);

  assign BusA = w_byp_a ? BusW : w_rd_a;
  assign BusB = w_byp_b ? BusW : w_rd_b;
`else
  assign BusA = w_rd_a;
  assign BusB = w_rd_b;
`endif

endmodule
